dense_layer_param: RTL and testbench

Parametrised fully-connected NN layer: holds a per-neuron weight and bias memory, consumes one input vector as an AXI-Stream of `input_dim` fixed-point samples, and computes all `N_NEURON` dot products in parallel. It then applies bias, arithmetic shift, ReLU and saturation, and streams results out `LANES` neurons per beat. It sits between layers in the inference chain as the general successor of the fixed 20-neuron/3-lane layer. Unlike that layer it has real backpressure, bias memory, saturation, length checking and a decoupled output buffer.

---
 rtl/dense_pkg.sv | 29 ++
 rtl/dense_mac_cell.sv | 68 ++++++
 rtl/dense_layer_param.sv | 197 +++++++++++++++++++
 tb/tb_dense_layer_param.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared constants and helpers for the dense layer: FSM state codes, index
// widths and the output ReLU/saturation function.
package dense_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_ACC   = 2'd2;
    localparam logic [1:0] ST_FLUSH = 2'd3;

    // Width of an index over n items; never below one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Clamp to [0, 2^(dw-1)-1]; caller truncates the result to dw bits.
    function automatic logic [63:0] sat_relu(input logic signed [63:0] v, input int unsigned dw);
        logic signed [63:0] vmax;
        logic [63:0]        r;
        vmax = (64'sd1 <<< (dw - 1)) - 64'sd1;
        if (v < 0)
            r = '0;
        else if (v > vmax)
            r = vmax;
        else
            r = v;
        return r;
    endfunction

endpackage

// File: rtl/dense_mac_cell.sv
// One neuron: weight RAM, bias register, two-stage MAC (registered weight
// read, then multiply-accumulate) and the combinational bias/shift/ReLU result.
module dense_mac_cell
    import dense_pkg::*;
#(
    parameter int MAX_DIM = 16,
    parameter int DW      = 16,
    parameter int FRAC    = 12,
    parameter int ACC_W   = 36,
    parameter int AW      = 4
) (
    input  logic          aclk,
    input  logic          areset,
    input  logic          w_we,
    input  logic          b_we,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          in_vld,
    input  logic          in_first,
    input  logic [AW-1:0] in_addr,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] res
);

    logic [DW-1:0]        wmem [MAX_DIM];
    logic signed [DW-1:0] bias_q;
    logic signed [DW-1:0] d_q;
    logic signed [DW-1:0] wt_q;
    logic                 vld_q, vld_d;
    logic                 first_q, first_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W:0]   sum;
    logic signed [ACC_W:0]   sh;

    // Weights and bias survive reset so a reset never forces a reload.
    always_ff @(posedge aclk) begin
        if (w_we) wmem[w_addr] <= w_data;
        if (b_we) bias_q <= w_data;
        d_q  <= in_data;
        wt_q <= wmem[in_addr];
    end

    always_comb begin
        vld_d   = in_vld;
        first_d = in_first;
        prod    = d_q * wt_q;
        acc_d   = acc_q;
        if (vld_q)
            acc_d = (first_q ? '0 : acc_q) + ACC_W'(prod);
        sum = (ACC_W+1)'(acc_q) + ((ACC_W+1)'(bias_q) <<< FRAC);
        sh  = sum >>> FRAC;
        res = DW'(sat_relu(64'(sh), DW));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            vld_q   <= 1'b0;
            first_q <= 1'b0;
            acc_q   <= '0;
        end else begin
            vld_q   <= vld_d;
            first_q <= first_d;
            acc_q   <= acc_d;
        end
    end

endmodule

// File: rtl/dense_layer_param.sv
// Parametrised fully-connected layer: weight load, streamed dot products over
// N_NEURON cells, and a decoupled output buffer drained LANES neurons per beat.
module dense_layer_param
    import dense_pkg::*;
#(
    parameter int N_NEURON = 20,
    parameter int LANES    = 3,
    parameter int MAX_DIM  = 16,
    parameter int DW       = 16,
    parameter int FRAC     = 12,
    parameter int ACC_W    = 36,
    localparam int NB      = (N_NEURON + LANES - 1) / LANES,
    localparam int DIM_W   = $clog2(MAX_DIM + 1),
    localparam int NW      = idx_w(N_NEURON)
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DIM_W-1:0]      input_dim,
    input  logic                  w_tvalid,
    output logic                  w_tready,
    input  logic [DW-1:0]         w_tdata,
    input  logic [NW-1:0]         w_tneuron,
    input  logic                  w_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic [DW-1:0]         s_tdata,
    input  logic                  s_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic [LANES*DW-1:0]   m_tdata,
    output logic                  m_tlast,
    output logic                  err_len
);

    localparam int AW  = idx_w(MAX_DIM);
    localparam int OBW = idx_w(NB);

    logic [1:0]       state_q, state_d;
    logic [DIM_W-1:0] waddr_q, waddr_d;
    logic [DIM_W-1:0] beat_q, beat_d;
    logic [DIM_W-1:0] dim_q, dim_d;
    logic             drain_q, drain_d;
    logic             err_q, err_d;
    logic             bvld_q, bvld_d;
    logic [OBW-1:0]   ob_q, ob_d;
    logic [N_NEURON-1:0][DW-1:0] res, buf_q, buf_d;
    logic [NB*LANES*DW-1:0]      pad;

    logic             w_acc, s_acc, w_we, b_we, buf_we, buf_free, ob_last;
    logic [DIM_W-1:0] idx, dim_cur;
    logic             at_dim, v_last, v_err;

    assign w_tready = ~areset && (state_q == ST_IDLE || state_q == ST_LOAD);
    // Weight words win over samples in IDLE, hence the w_tvalid term.
    assign s_tready = ~areset && ((state_q == ST_IDLE && !w_tvalid) ||
                                  (state_q == ST_ACC && !drain_q));
    assign w_acc    = w_tvalid && w_tready;
    assign s_acc    = s_tvalid && s_tready;

    assign idx      = (state_q == ST_IDLE) ? '0 : beat_q;
    assign dim_cur  = (state_q == ST_IDLE) ? input_dim : dim_q;
    assign at_dim   = (idx == dim_cur - 1'b1);
    // The MAX_DIM cap keeps an illegal input_dim from running past the RAM.
    assign v_last   = s_tlast || at_dim || (idx == DIM_W'(MAX_DIM - 1));
    assign v_err    = v_last && !(s_tlast && at_dim);

    assign ob_last  = (ob_q == OBW'(NB - 1));
    assign buf_free = !bvld_q || (m_tready && ob_last);

    always_comb begin
        state_d = state_q;
        waddr_d = waddr_q;
        beat_d  = beat_q;
        dim_d   = dim_q;
        drain_d = drain_q;
        err_d   = err_q;
        bvld_d  = bvld_q;
        ob_d    = ob_q;
        buf_d   = buf_q;
        w_we    = 1'b0;
        b_we    = 1'b0;
        buf_we  = 1'b0;

        if (s_acc) begin
            state_d = ST_ACC;
            dim_d   = dim_cur;
            beat_d  = idx + 1'b1;
            drain_d = v_last;
            if (v_err) err_d = 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_LOAD: begin
                if (w_acc) begin
                    if (w_tlast || waddr_q == DIM_W'(MAX_DIM)) begin
                        b_we    = 1'b1;
                        waddr_d = '0;
                        state_d = ST_IDLE;
                        if (!w_tlast) err_d = 1'b1;
                    end else begin
                        w_we    = 1'b1;
                        waddr_d = waddr_q + 1'b1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_ACC: begin
                if (drain_q) begin
                    drain_d = 1'b0;
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (buf_free) begin
                    buf_we  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bvld_q && m_tready) begin
            if (ob_last) begin
                bvld_d = 1'b0;
                ob_d   = '0;
            end else begin
                ob_d   = ob_q + 1'b1;
            end
        end
        if (buf_we) begin
            bvld_d = 1'b1;
            ob_d   = '0;
            buf_d  = res;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q <= ST_IDLE;
            waddr_q <= '0;
            beat_q  <= '0;
            dim_q   <= '0;
            drain_q <= 1'b0;
            err_q   <= 1'b0;
            bvld_q  <= 1'b0;
            ob_q    <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            beat_q  <= beat_d;
            dim_q   <= dim_d;
            drain_q <= drain_d;
            err_q   <= err_d;
            bvld_q  <= bvld_d;
            ob_q    <= ob_d;
            buf_q   <= buf_d;
        end
    end

    for (genvar n = 0; n < N_NEURON; n++) begin : g_cell
        dense_mac_cell #(
            .MAX_DIM (MAX_DIM),
            .DW      (DW),
            .FRAC    (FRAC),
            .ACC_W   (ACC_W),
            .AW      (AW)
        ) u_cell (
            .aclk     (aclk),
            .areset   (areset),
            .w_we     (w_we && (w_tneuron == NW'(n))),
            .b_we     (b_we && (w_tneuron == NW'(n))),
            .w_addr   (waddr_q[AW-1:0]),
            .w_data   (w_tdata),
            .in_vld   (s_acc),
            .in_first (state_q == ST_IDLE),
            .in_addr  (idx[AW-1:0]),
            .in_data  (s_tdata),
            .res      (res[n])
        );
    end

    // Lanes past the last neuron read the zero padding.
    always_comb begin
        pad = '0;
        pad[N_NEURON*DW-1:0] = buf_q;
        m_tdata = '0;
        for (int j = 0; j < NB; j++)
            if (bvld_q && ob_q == OBW'(j))
                m_tdata = pad[j*LANES*DW +: LANES*DW];
    end

    assign m_tvalid = bvld_q;
    assign m_tlast  = bvld_q && ob_last;
    assign err_len  = err_q;

endmodule

// File: tb/tb_dense_layer_param.sv
// Randomised scoreboard bench for dense_layer_param (4 neurons, 2 lanes).
module tb_dense_layer_param;

    localparam int NN = 4;
    localparam int LN = 2;
    localparam int MD = 16;
    localparam int NB = 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [4:0]  input_dim = '0;
    logic        w_tvalid = 1'b0, w_tready, w_tlast = 1'b0;
    logic [15:0] w_tdata = '0;
    logic [1:0]  w_tneuron = '0;
    logic        s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
    logic [15:0] s_tdata = '0;
    logic        m_tvalid, m_tready = 1'b0, m_tlast, err_len;
    logic [31:0] m_tdata;

    always #5 aclk = ~aclk;

    dense_layer_param #(
        .N_NEURON(NN), .LANES(LN), .MAX_DIM(MD), .DW(16), .FRAC(12), .ACC_W(36)
    ) dut (
        .aclk(aclk), .areset(areset), .input_dim(input_dim),
        .w_tvalid(w_tvalid), .w_tready(w_tready), .w_tdata(w_tdata),
        .w_tneuron(w_tneuron), .w_tlast(w_tlast),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
        .err_len(err_len)
    );

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } beat_t;

    logic signed [15:0] W [NN][MD];
    logic signed [15:0] B [NN];
    beat_t exp_q[$];
    int n_cmp = 0;
    int n_bad = 0;
    int rdy_mode = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Reference: plain dot product over the samples the layer actually uses.
    task automatic model_vec(input logic [15:0] xs[$], input int used);
        logic [15:0] r [NN];
        longint acc;
        for (int n = 0; n < NN; n++) begin
            acc = 0;
            for (int k = 0; k < used; k++)
                acc += longint'($signed(xs[k])) * longint'(W[n][k]);
            acc = (acc + longint'(B[n]) * 4096) >>> 12;
            if (acc < 0) r[n] = 16'h0000;
            else if (acc > 32767) r[n] = 16'h7FFF;
            else r[n] = 16'(acc);
        end
        for (int j = 0; j < NB; j++)
            exp_q.push_back('{data: {r[2*j+1], r[2*j]}, last: (j == NB - 1)});
    endtask

    task automatic send_w(input logic [15:0] d, input int n, input bit last);
        bit ok;
        int c = 0;
        w_tvalid = 1'b1; w_tdata = d; w_tneuron = 2'(n); w_tlast = last;
        do begin
            @(negedge aclk); ok = w_tready;
            @(posedge aclk); #1; c++;
        end while (!ok && c < 200);
        if (!ok) expire("w_handshake");
        w_tvalid = 1'b0; w_tlast = 1'b0;
    endtask

    task automatic send_s(input logic [15:0] d, input bit last);
        bit ok;
        int c = 0;
        s_tvalid = 1'b1; s_tdata = d; s_tlast = last;
        do begin
            @(negedge aclk); ok = s_tready;
            @(posedge aclk); #1; c++;
        end while (!ok && c < 200);
        if (!ok) expire("s_handshake");
        s_tvalid = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic load_row(input int n, input bit rnd, input logic [15:0] wval,
                            input logic [15:0] bias, input bit tl);
        logic [15:0] w;
        for (int k = 0; k < MD; k++) begin
            w = rnd ? 16'($urandom_range(0, 32'h2000) - 32'h1000) : wval;
            W[n][k] = w;
            send_w(w, n, 1'b0);
        end
        B[n] = bias;
        send_w(bias, n, tl);
    endtask

    // Vector ends at input_dim or at the s_tlast beat, whichever comes first.
    task automatic send_vec(input logic [15:0] xs[$], input int dim, input int tl_at);
        int used;
        used = dim;
        if (tl_at >= 0 && tl_at + 1 < used) used = tl_at + 1;
        input_dim = 5'(dim);
        model_vec(xs, used);
        for (int k = 0; k < used; k++)
            send_s(xs[k], k == tl_at);
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 3000) begin
            @(posedge aclk); c++;
        end
        #1;
        if (exp_q.size() != 0) expire("drain");
    endtask

    task automatic pulse_reset();
        areset = 1'b1;
        repeat (2) @(posedge aclk);
        #1 areset = 1'b0;
    endtask

    initial forever begin
        @(posedge aclk); #1;
        case (rdy_mode)
            0:       m_tready = 1'b1;
            1:       m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    end

    initial begin : monitor
        beat_t       e;
        logic [31:0] hold_d = '0;
        bit          stall = 1'b0;
        forever begin
            @(negedge aclk);
            if (areset) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    chk("stall_valid", m_tvalid, 1);
                    chk("stall_data", m_tdata, hold_d);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) begin
                        expire("unexpected_beat");
                    end else begin
                        e = exp_q.pop_front();
                        chk("beat_data", m_tdata, e.data);
                        chk("beat_last", m_tlast, e.last);
                    end
                end
                stall  = m_tvalid && !m_tready;
                hold_d = m_tdata;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [15:0] xs[$];
        int c;

        @(negedge aclk);
        chk("rst_s_tready", s_tready, 0);
        chk("rst_m_tvalid", m_tvalid, 0);
        chk("rst_m_tlast", m_tlast, 0);
        chk("rst_m_tdata", m_tdata, 0);
        chk("rst_err_len", err_len, 0);
        @(posedge aclk); #1 areset = 1'b0;
        @(negedge aclk);
        chk("idle_s_tready", s_tready, 1);
        chk("idle_w_tready", w_tready, 1);
        @(posedge aclk); #1;

        // Unity weights, inputs 1.0 and 2.0, plus first-beat latency
        for (int n = 0; n < NN; n++) load_row(n, 0, 16'h1000, 16'h0000, 1);
        xs.delete(); xs.push_back(16'h1000); xs.push_back(16'h2000);
        send_vec(xs, 2, 1);
        chk("lat_t1_valid", m_tvalid, 0);
        @(posedge aclk); #1;
        chk("lat_t2_valid", m_tvalid, 0);
        @(posedge aclk); #1;
        chk("lat_t3_valid", m_tvalid, 1);
        wait_drain();

        // Negative bias on neuron 0 clamps to zero
        load_row(0, 0, 16'h1000, 16'hF000, 1);
        for (int n = 1; n < NN; n++) load_row(n, 0, 16'h1000, 16'h0000, 1);
        xs.delete(); xs.push_back(16'h0800);
        send_vec(xs, 1, 0);
        wait_drain();

        // Full-length vector of maximum values saturates
        for (int n = 0; n < NN; n++) load_row(n, 0, 16'h7FFF, 16'h0000, 1);
        xs.delete();
        for (int k = 0; k < MD; k++) xs.push_back(16'h7FFF);
        send_vec(xs, MD, MD - 1);
        wait_drain();
        chk("sat_err_len", err_len, 0);

        // Random weights, biases, lengths and output backpressure
        for (int n = 0; n < NN; n++)
            load_row(n, 1, 16'h0, 16'($urandom_range(0, 32'h1000) - 32'h800), 1);
        rdy_mode = 1;
        for (int v = 0; v < 8; v++) begin
            int d;
            d = int'($urandom_range(1, MD));
            xs.delete();
            for (int k = 0; k < d; k++) xs.push_back(16'($urandom_range(0, 32'h2000) - 32'h1000));
            send_vec(xs, d, d - 1);
        end
        wait_drain();
        rdy_mode = 0;

        // Output held off: second vector must wait in FLUSH
        rdy_mode = 2;
        @(posedge aclk); #1;
        for (int v = 0; v < 2; v++) begin
            xs.delete();
            for (int k = 0; k < 3; k++) xs.push_back(16'($urandom_range(0, 32'h2000) - 32'h1000));
            send_vec(xs, 3, 2);
        end
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        chk("flush_stall_sready", s_tready, 0);
        chk("flush_stall_mvalid", m_tvalid, 1);
        repeat (15) @(posedge aclk);
        #1 rdy_mode = 0;
        wait_drain();
        @(negedge aclk);
        chk("after_stall_sready", s_tready, 1);
        @(posedge aclk); #1;

        // Early s_tlast: 3 of 4 samples used, sticky error
        xs.delete();
        for (int k = 0; k < 3; k++) xs.push_back(16'($urandom_range(0, 32'h2000) - 32'h1000));
        send_vec(xs, 4, 2);
        wait_drain();
        chk("early_tlast_err", err_len, 1);
        repeat (3) @(posedge aclk);
        #1 chk("err_sticky", err_len, 1);
        pulse_reset();
        chk("err_cleared", err_len, 0);

        // Missing s_tlast at input_dim
        xs.delete(); xs.push_back(16'h0C00); xs.push_back(16'hF400);
        send_vec(xs, 2, -1);
        wait_drain();
        chk("missing_tlast_err", err_len, 1);
        pulse_reset();

        // Weight row overflow: 17th word becomes the bias and flags an error
        load_row(1, 1, 16'h0, 16'h0400, 0);
        chk("row_overflow_err", err_len, 1);
        xs.delete();
        for (int k = 0; k < 5; k++) xs.push_back(16'($urandom_range(0, 32'h2000) - 32'h1000));
        send_vec(xs, 5, 4);
        wait_drain();
        pulse_reset();

        // Reset mid-drain, then the same vector reproduces identical results
        rdy_mode = 2;
        @(posedge aclk); #1;
        xs.delete();
        for (int k = 0; k < 6; k++) xs.push_back(16'($urandom_range(0, 32'h2000) - 32'h1000));
        send_vec(xs, 6, 5);
        c = 0;
        do begin
            @(negedge aclk); c++;
        end while (!m_tvalid && c < 20);
        if (!m_tvalid) expire("drain_valid");
        @(posedge aclk); #1 areset = 1'b1;
        exp_q.delete();
        @(posedge aclk); #1;
        chk("rst_drain_valid", m_tvalid, 0);
        chk("rst_drain_data", m_tdata, 0);
        areset = 1'b0;
        rdy_mode = 0;
        @(posedge aclk); #1;
        send_vec(xs, 6, 5);
        wait_drain();

        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
